// File: rtl/instr_fetch_unit.sv
// Program counter and fetch stage for the Troy WideWord pipeline.
// Drives a word-addressed instr_mem and captures its combinational read
// into the IF/ID register. Supports sequential fetch, branch redirect with
// flush, decode stall and halt on HALT_WORD.
module instr_fetch_unit #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic [31:0] imem_instr,
    output logic [31:0] instr_addr,
    output logic        imem_enb,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic        halted
);

    localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);
    localparam logic [31:0] LAST_PC = DEPTH_W - 32'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] pc;
    logic        fetch_halt;

    // A HALT_WORD fetch only takes effect when neither redirect nor stall wins.
    assign fetch_halt = (state == RUN) && !br_taken && !stall && (imem_instr == HALT_WORD);

    assign instr_addr = pc;
    // Memory enable is a state decode, forced low while reset is asserted.
    assign imem_enb   = rst && (state == RUN);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE lasts one cycle, RUN leaves only on a HALT fetch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = RUN;
            RUN:     if (fetch_halt) next_state = HALT;
            HALT:    next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    // PC and IF/ID register update, branch > stall > halt > sequential.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc       <= RESET_PC;
            if_instr <= NOP_WORD;
            if_pc    <= '0;
            if_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if_valid <= 1'b0;
                end
                RUN: begin
                    if (br_taken) begin
                        pc       <= br_target % DEPTH_W;
                        if_instr <= NOP_WORD;
                        if_valid <= 1'b0;
                    end else if (stall) begin
                        pc       <= pc;
                    end else if (imem_instr == HALT_WORD) begin
                        if_instr <= HALT_WORD;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        halted   <= 1'b1;
                    end else begin
                        if_instr <= imem_instr;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        pc       <= (pc == LAST_PC) ? '0 : pc + 32'd1;
                    end
                end
                default: begin
                    pc <= pc;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural instr_mem.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] imem_instr;
    logic [31:0] instr_addr;
    logic        imem_enb;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        halted;

    logic [31:0] mem [256];

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(
        .MEM_DEPTH (256),
        .RESET_PC  (32'h0000_0000),
        .NOP_WORD  (32'h0000_0000),
        .HALT_WORD (32'hFFFF_FFFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_instr (imem_instr),
        .instr_addr (instr_addr),
        .imem_enb   (imem_enb),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_valid   (if_valid),
        .halted     (halted)
    );

    // Combinational instruction memory.
    assign imem_instr = mem[instr_addr[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) mem[i] = 32'(i + 1);
        rst = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = '0;
        tick();
        tick();
        checks++; if (instr_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %h exp %h", instr_addr, 32'd0); end
        checks++; if (imem_enb !== 1'b0) begin errors++; $display("FAIL reset_enb got %b exp 0", imem_enb); end
        checks++; if (if_instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %h exp 0", if_instr); end
        checks++; if (if_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", if_pc); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
        rst = 1'b1;
        // IDLE cycle: no enable yet
        checks++; if (imem_enb !== 1'b0) begin errors++; $display("FAIL idle_enb got %b exp 0", imem_enb); end
        tick();
        checks++; if (imem_enb !== 1'b1) begin errors++; $display("FAIL run_enb got %b exp 1", imem_enb); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL run0_valid got %b exp 0", if_valid); end
        checks++; if (instr_addr !== 32'd0) begin errors++; $display("FAIL run0_addr got %h exp 0", instr_addr); end
    endtask

    task automatic test_sequential();
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++; if (if_instr !== 32'(k)) begin errors++; $display("FAIL seq_instr got %h exp %h", if_instr, 32'(k)); end
            checks++; if (if_pc !== 32'(k - 1)) begin errors++; $display("FAIL seq_pc got %h exp %h", if_pc, 32'(k - 1)); end
            checks++; if (instr_addr !== 32'(k)) begin errors++; $display("FAIL seq_addr got %h exp %h", instr_addr, 32'(k)); end
            checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL seq_valid got %b exp 1", if_valid); end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (instr_addr !== 32'd5) begin errors++; $display("FAIL stall_addr got %h exp 5", instr_addr); end
            checks++; if (if_instr !== 32'd5) begin errors++; $display("FAIL stall_instr got %h exp 5", if_instr); end
            checks++; if (if_pc !== 32'd4) begin errors++; $display("FAIL stall_pc got %h exp 4", if_pc); end
            checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b exp 1", if_valid); end
        end
        stall = 1'b0;
        tick();
        checks++; if (if_instr !== 32'd6) begin errors++; $display("FAIL resume_instr got %h exp 6", if_instr); end
        checks++; if (if_pc !== 32'd5) begin errors++; $display("FAIL resume_pc got %h exp 5", if_pc); end
        checks++; if (instr_addr !== 32'd6) begin errors++; $display("FAIL resume_addr got %h exp 6", instr_addr); end
    endtask

    task automatic test_branch();
        stall = 1'b1; br_taken = 1'b1; br_target = 32'd40;
        tick();
        stall = 1'b0; br_taken = 1'b0;
        checks++; if (instr_addr !== 32'd40) begin errors++; $display("FAIL br_addr got %h exp 40", instr_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL br_valid got %b exp 0", if_valid); end
        checks++; if (if_instr !== 32'd0) begin errors++; $display("FAIL br_instr got %h exp 0", if_instr); end
        tick();
        checks++; if (if_instr !== 32'd41) begin errors++; $display("FAIL br_fetch_instr got %h exp 41", if_instr); end
        checks++; if (if_pc !== 32'd40) begin errors++; $display("FAIL br_fetch_pc got %h exp 40", if_pc); end
        // target beyond depth wraps modulo 256, then PC wraps 255 -> 0
        br_taken = 1'b1; br_target = 32'h0000_01FF;
        tick();
        br_taken = 1'b0;
        checks++; if (instr_addr !== 32'd255) begin errors++; $display("FAIL brmod_addr got %h exp ff", instr_addr); end
        tick();
        checks++; if (if_instr !== 32'h100) begin errors++; $display("FAIL wrap_instr got %h exp 100", if_instr); end
        checks++; if (if_pc !== 32'd255) begin errors++; $display("FAIL wrap_pc got %h exp ff", if_pc); end
        checks++; if (instr_addr !== 32'd0) begin errors++; $display("FAIL wrap_addr got %h exp 0", instr_addr); end
        tick();
        checks++; if (if_instr !== 32'd1) begin errors++; $display("FAIL postwrap_instr got %h exp 1", if_instr); end
        checks++; if (instr_addr !== 32'd1) begin errors++; $display("FAIL postwrap_addr got %h exp 1", instr_addr); end
    endtask

    task automatic test_halt();
        mem[7] = 32'hFFFF_FFFF;
        for (int k = 0; k < 6; k++) tick();
        checks++; if (instr_addr !== 32'd7) begin errors++; $display("FAIL prehalt_addr got %h exp 7", instr_addr); end
        tick();
        checks++; if (if_instr !== 32'hFFFF_FFFF) begin errors++; $display("FAIL halt_instr got %h exp ffffffff", if_instr); end
        checks++; if (if_pc !== 32'd7) begin errors++; $display("FAIL halt_pc got %h exp 7", if_pc); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b exp 1", halted); end
        checks++; if (imem_enb !== 1'b0) begin errors++; $display("FAIL halt_enb got %b exp 0", imem_enb); end
        checks++; if (instr_addr !== 32'd7) begin errors++; $display("FAIL halt_addr got %h exp 7", instr_addr); end
        // branch and stall are ignored while halted
        br_taken = 1'b1; br_target = 32'd20; stall = 1'b1;
        tick();
        tick();
        br_taken = 1'b0; stall = 1'b0;
        checks++; if (instr_addr !== 32'd7) begin errors++; $display("FAIL halt_hold_addr got %h exp 7", instr_addr); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_hold_flag got %b exp 1", halted); end
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL halt_hold_valid got %b exp 1", if_valid); end
        rst = 1'b0;
        tick();
        checks++; if (instr_addr !== 32'd0) begin errors++; $display("FAIL halt_rst_addr got %h exp 0", instr_addr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_rst_flag got %b exp 0", halted); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL halt_rst_valid got %b exp 0", if_valid); end
        rst = 1'b1;
        checks++; if (imem_enb !== 1'b0) begin errors++; $display("FAIL halt_idle_enb got %b exp 0", imem_enb); end
        tick();
        checks++; if (imem_enb !== 1'b1) begin errors++; $display("FAIL halt_run_enb got %b exp 1", imem_enb); end
        mem[7] = 32'd8;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) tick();
        checks++; if (instr_addr !== 32'd3) begin errors++; $display("FAIL mid_pre_addr got %h exp 3", instr_addr); end
        rst = 1'b0; br_taken = 1'b1; stall = 1'b1; br_target = 32'd99;
        tick();
        checks++; if (instr_addr !== 32'd0) begin errors++; $display("FAIL mid_addr got %h exp 0", instr_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", if_valid); end
        checks++; if (if_instr !== 32'd0) begin errors++; $display("FAIL mid_instr got %h exp 0", if_instr); end
        checks++; if (if_pc !== 32'd0) begin errors++; $display("FAIL mid_pc got %h exp 0", if_pc); end
        checks++; if (imem_enb !== 1'b0) begin errors++; $display("FAIL mid_enb got %b exp 0", imem_enb); end
        rst = 1'b1; br_taken = 1'b0; stall = 1'b0;
        checks++; if (imem_enb !== 1'b0) begin errors++; $display("FAIL mid_idle_enb got %b exp 0", imem_enb); end
        tick();
        checks++; if (imem_enb !== 1'b1) begin errors++; $display("FAIL mid_run_enb got %b exp 1", imem_enb); end
        tick();
        checks++; if (if_instr !== 32'd1) begin errors++; $display("FAIL mid_fetch_instr got %h exp 1", if_instr); end
        checks++; if (instr_addr !== 32'd1) begin errors++; $display("FAIL mid_fetch_addr got %h exp 1", instr_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
